// File: rtl/log_drain_reader_pkg.sv
// Shared definitions for the debug-log drain reader.
//   DEBUG_CAPACITY / DEBUG_DATA : register offsets seen by the host
//   LOG_LOG_DEPTH               : log2 of the upstream log buffer depth
//   WORD_W                      : width of one log word and of a register read
package log_drain_reader_pkg;

    localparam int WORD_W        = 32;
    localparam int LOG_LOG_DEPTH = 14;

    localparam logic [7:0] DEBUG_CAPACITY = 8'h00;
    localparam logic [7:0] DEBUG_DATA     = 8'h04;

endpackage : log_drain_reader_pkg

// File: rtl/log_drain_reader_if.sv
// Bus bundle between the upstream log buffer, the host register port and the
// drain reader.
//   log_valid/log_ready/log_data/log_count : upstream log buffer head + occupancy
//   rd_valid/rd_ready/rd_addr              : host register-read request
//   resp_valid/resp_ready/resp_data        : host register-read response
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid && ready are both 1; the payload must be stable while valid is
// high and ready is low, and valid must not drop before the transfer.
// modport slave is the drain reader, modport master is the environment.
interface log_drain_reader_if
    import log_drain_reader_pkg::*;
#(
    parameter int N_WORDS   = 16,
    parameter int LOG_DEPTH = LOG_LOG_DEPTH
) ();

    logic                        log_valid;
    logic                        log_ready;
    logic [N_WORDS*WORD_W-1:0]   log_data;
    logic [LOG_DEPTH:0]          log_count;

    logic                        rd_valid;
    logic                        rd_ready;
    logic [7:0]                  rd_addr;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [WORD_W-1:0]           resp_data;

    modport slave (
        input  log_valid, log_data, log_count,
        output log_ready,
        input  rd_valid, rd_addr,
        output rd_ready,
        output resp_valid, resp_data,
        input  resp_ready
    );

    modport master (
        output log_valid, log_data, log_count,
        input  log_ready,
        output rd_valid, rd_addr,
        input  rd_ready,
        input  resp_valid, resp_data,
        output resp_ready
    );

endinterface : log_drain_reader_if

// File: rtl/log_drain_reader.sv
// Drains multi-word debug log entries one 32-bit word per host register read.
// One entry is popped into a shadow register, then each DEBUG_DATA read returns
// the next word; DEBUG_CAPACITY returns upstream occupancy plus the shadow.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   bus (slave)      : log buffer, register request and response channels
//   dbg_state        : 1 while a response is outstanding (RESP state)
//   dbg_shadow_valid : shadow register holds an entry
//   dbg_word_idx     : index of the next word to be returned
module log_drain_reader
    import log_drain_reader_pkg::*;
#(
    parameter int  N_WORDS   = 16,
    parameter int  LOG_DEPTH = LOG_LOG_DEPTH,
    localparam int IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    log_drain_reader_if.slave  bus,
    output logic               dbg_state,
    output logic               dbg_shadow_valid,
    output logic [IDX_W-1:0]   dbg_word_idx
);

    localparam int CAP_W = LOG_DEPTH + 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                     state;
    logic                       shadow_valid;
    logic [IDX_W-1:0]           word_idx;
    logic [N_WORDS*WORD_W-1:0]  shadow_data;
    logic                       resp_valid;
    logic [WORD_W-1:0]          resp_data;

    logic                       pop;
    logic                       rd_fire;
    logic                       data_rd;
    logic                       last_word;
    logic [CAP_W-1:0]           capacity;
    logic [WORD_W-1:0]          cur_word;
    logic [WORD_W-1:0]          rd_value;

    // Reset gates both ready outputs so nothing is popped or accepted while
    // rstn is low.
    assign bus.log_ready = rstn && !shadow_valid;
    assign bus.rd_ready  = rstn && (state == IDLE);

    assign pop       = bus.log_valid && bus.log_ready;
    assign rd_fire   = bus.rd_valid && bus.rd_ready;
    // A data read only has side effects when the shadow holds an entry.
    assign data_rd   = rd_fire && (bus.rd_addr == DEBUG_DATA) && shadow_valid;
    assign last_word = (word_idx == IDX_W'(N_WORDS - 1));

    // One extra bit so log_count at full depth plus the shadow cannot wrap.
    assign capacity = {1'b0, bus.log_count} + CAP_W'(shadow_valid);
    assign cur_word = shadow_data[word_idx*WORD_W +: WORD_W];

    always_comb begin
        rd_value = '0;
        case (bus.rd_addr)
            DEBUG_CAPACITY: rd_value = WORD_W'(capacity);
            DEBUG_DATA:     if (shadow_valid) rd_value = cur_word;
            default:        rd_value = '0;
        endcase
    end

    // Pop and data read are mutually exclusive: pop needs shadow_valid=0,
    // data_rd needs shadow_valid=1. Clearing shadow_valid on the last word
    // therefore lets the next pop happen one cycle later, never the same one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            shadow_valid <= 1'b0;
            word_idx     <= '0;
            shadow_data  <= '0;
        end else begin
            if (pop) begin
                shadow_data  <= bus.log_data;
                shadow_valid <= 1'b1;
                word_idx     <= '0;
            end

            case (state)
                IDLE: begin
                    if (rd_fire) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= rd_value;
                        if (data_rd) begin
                            if (last_word) begin
                                shadow_valid <= 1'b0;
                                word_idx     <= '0;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_data;

    assign dbg_state        = (state == RESP);
    assign dbg_shadow_valid = shadow_valid;
    assign dbg_word_idx     = word_idx;

endmodule : log_drain_reader

// File: doc/log_drain_reader.md
LOG_DRAIN_READER -- requirements
Module: log_drain_reader

Interface
REQ-001 Parameter: N_WORDS, default 16, number of 32-bit words per debug log entry.
REQ-002 Parameter: LOG_DEPTH, default 14 (LOG_LOG_DEPTH), log2 of the upstream log buffer depth.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  sole clock; all state on rising edge.
REQ-005 Port: rstn  in  1  asynchronous active-low reset.
REQ-006 Port: log_valid  in  1  upstream log buffer has an entry at its head.
REQ-007 Port: log_data  in  N_WORDS*32  head entry; word k = bits [32k+31:32k].
REQ-008 Port: log_ready  out  1  pop strobe; the entry is consumed when log_valid&&log_ready.
REQ-009 Port: log_count  in  LOG_DEPTH+1  upstream occupancy.
REQ-010 Port: rd_valid  in  1  host (OCL slave) register-read request.
REQ-011 Port: rd_addr  in  8  register offset.
REQ-012 Port: rd_ready  out  1  request accepted when rd_valid&&rd_ready.
REQ-013 Port: resp_valid  out  1  read response valid.
REQ-014 Port: resp_data  out  32  read response data.
REQ-015 Port: resp_ready  in  1  host accepts the response.

Function
REQ-016 The shadow register SHALL hold one entry, with shadow_valid and word_idx (clog2(N_WORDS) bits).
REQ-017 log_ready SHALL be combinational !shadow_valid; on pop, the shadow SHALL capture log_data, set shadow_valid=1 and set word_idx=0 next cycle.
REQ-018 The FSM SHALL have exactly two states: IDLE and RESP.
REQ-019 rd_ready SHALL be 1 in IDLE and 0 in RESP.
REQ-020 An accepted request SHALL move the FSM to RESP, and resp_valid SHALL be 1 from the next cycle, giving 1-cycle latency.
REQ-021 In RESP, resp_valid and resp_data SHALL hold stable until resp_ready; the FSM SHALL return to IDLE on the cycle resp_valid&&resp_ready.
REQ-022 Address 0x00 (DEBUG_CAPACITY) SHALL return zero-extended log_count + shadow_valid, computed at acceptance; the width is LOG_DEPTH+2 with no overflow.
REQ-023 Address 0x04 (DEBUG_DATA) with shadow_valid=1 SHALL return word[word_idx] and increment word_idx.
REQ-024 When word_idx==N_WORDS-1 at acceptance, shadow_valid SHALL clear and word_idx SHALL wrap to 0.
REQ-025 Address 0x04 with shadow_valid=0 SHALL return 0 and SHALL NOT change state.
REQ-026 Any other address SHALL return 0 with no side effect.
REQ-027 Capacity/data values SHALL be sampled at acceptance and registered into resp_data, not read at resp time.
REQ-028 Simultaneous events: a last-word read clearing shadow_valid SHALL NOT pop in the same cycle; the pop occurs the following cycle if log_valid.
REQ-029 A pop and a data read SHALL never coincide, because a pop requires shadow_valid=0.
REQ-030 Entries SHALL never be dropped or duplicated.
REQ-031 Words SHALL be delivered in order 0..N_WORDS-1 per entry, and entries SHALL be delivered in FIFO order.

Reset
REQ-032 While rstn=0, the FSM SHALL be IDLE, shadow_valid=0, word_idx=0, resp_valid=0, and resp_data=0.
REQ-033 While rstn=0, log_ready SHALL be 0 (gated by reset), and rd_ready SHALL be 0.
REQ-034 Reset mid-response or mid-entry SHALL discard the shadow entry and any pending response; no pop SHALL occur until the first cycle after rstn rises.

Structure
REQ-035 The DEBUG_CAPACITY/DEBUG_DATA offsets SHALL live in the shared chronos package (addr_map), as SHALL LOG_LOG_DEPTH.
REQ-036 The state enum SHALL be local to the module.
REQ-037 The block SHALL be a single module with no sub-modules; a word-select mux is inline.

Verification
REQ-038 Scenario: reset, then an entry with words 0x100+k is presented, N_WORDS=16 -> log_ready pulses once; 16 reads of 0x04 return 0x100..0x10F in order; the 17th read returns 0.
REQ-039 Scenario: log_count=5 and shadow loaded, read 0x00 -> resp_data=6; with an empty shadow and log_count=0 -> 0.
REQ-040 Scenario: resp_ready held low 10 cycles -> resp_valid/resp_data stable; rd_ready=0 throughout; no word_idx advance.
REQ-041 Scenario: two back-to-back entries A,B with log_valid constant -> the pop of B occurs exactly 1 cycle after the last-word read of A is accepted; B words follow.
REQ-042 Scenario: rstn asserted after 7 words read -> outputs reset immediately; after release, the next entry is popped fresh and word 0 of the new entry is returned.
REQ-043 Scenario: read 0x08 -> resp_data=0; shadow and word_idx unchanged.
